// File: rtl/exec_unit.sv
// exec_unit: execute stage of the 8-bit two-byte-instruction CPU.
// Runs each instruction over two stage-control phases (execa, execb):
// execa drives the RAM strobes and latches immediate operands, execb
// commits accumulator/flag updates, jumps and halt.
// Build option: define ALU_SHIFT_EN to give opcodes D (SHL) and E (SHR)
// shift behaviour; left undefined they are plain NOPs.
module exec_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       execa,
  input  logic       execb,
  input  logic [7:0] ira,
  input  logic [7:0] irb,
  input  logic [7:0] mem_q,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_data,
  output logic       mem_rden,
  output logic       mem_wren,
  output logic       pc_load,
  output logic [7:0] pc_target,
  output logic       halt,
  output logic [7:0] acc,
  output logic       zf,
  output logic       cf
);

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_LD   = 4'h2,
    OP_ST   = 4'h3,
    OP_ADD  = 4'h4,
    OP_SUB  = 4'h5,
    OP_AND  = 4'h6,
    OP_OR   = 4'h7,
    OP_ADDI = 4'h8,
    OP_JMP  = 4'h9,
    OP_JZ   = 4'hA,
    OP_JC   = 4'hB,
    OP_HLT  = 4'hC,
    OP_SHL  = 4'hD,
    OP_SHR  = 4'hE,
    OP_NOP2 = 4'hF
  } opcode_t;

  logic [7:0] r_acc;
  logic       r_zf;
  logic       r_cf;
  logic       r_halt;
  logic [7:0] r_opa;

  opcode_t    w_op;
  logic       w_a_active;
  logic       w_b_active;
  logic       w_imm_op;
  logic       w_mem_rd_op;
  logic [7:0] w_acc_next;
  logic       w_zf_next;
  logic       w_cf_next;
  logic       w_halt_next;
  logic       w_upd_zf;
  logic [8:0] w_sum9;
  logic       w_jump_taken;

  assign w_op = opcode_t'(ira[7:4]);

  // Phase qualification: halt freezes everything, execb wins over execa
  // when both are asserted, and reset forces all strobes low.
  assign w_a_active = execa & ~execb & ~r_halt & ~rst;
  assign w_b_active = execb & ~r_halt & ~rst;

  assign w_imm_op    = (w_op == OP_LDI) || (w_op == OP_ADDI);
  assign w_mem_rd_op = (w_op == OP_LD) || (w_op == OP_ADD) || (w_op == OP_SUB) ||
                       (w_op == OP_AND) || (w_op == OP_OR);

  // RAM interface is only driven during a qualified execa cycle.
  always_comb begin
    mem_addr = 8'h00;
    mem_data = 8'h00;
    mem_rden = 1'b0;
    mem_wren = 1'b0;
    if (w_a_active) begin
      mem_addr = irb;
      mem_data = r_acc;
      mem_rden = w_mem_rd_op;
      mem_wren = (w_op == OP_ST);
    end
  end

  // Branch decision uses the flags as they stand at the start of execb.
  always_comb begin
    w_jump_taken = 1'b0;
    case (w_op)
      OP_JMP:  w_jump_taken = 1'b1;
      OP_JZ:   w_jump_taken = r_zf;
      OP_JC:   w_jump_taken = r_cf;
      default: w_jump_taken = 1'b0;
    endcase
    pc_load   = w_b_active & w_jump_taken;
    pc_target = pc_load ? irb : 8'h00;
  end

  // ALU: next accumulator/flags/halt for the instruction finishing in execb.
  always_comb begin
    w_acc_next  = r_acc;
    w_zf_next   = r_zf;
    w_cf_next   = r_cf;
    w_halt_next = r_halt;
    w_upd_zf    = 1'b0;
    w_sum9      = 9'h000;
    case (w_op)
      OP_LDI: begin
        w_acc_next = r_opa;
        w_upd_zf   = 1'b1;
      end
      OP_LD: begin
        w_acc_next = mem_q;
        w_upd_zf   = 1'b1;
      end
      OP_ADD: begin
        w_sum9     = {1'b0, r_acc} + {1'b0, mem_q};
        w_acc_next = w_sum9[7:0];
        w_cf_next  = w_sum9[8];
        w_upd_zf   = 1'b1;
      end
      OP_SUB: begin
        // Bit 8 of the 9-bit difference is the borrow.
        w_sum9     = {1'b0, r_acc} - {1'b0, mem_q};
        w_acc_next = w_sum9[7:0];
        w_cf_next  = w_sum9[8];
        w_upd_zf   = 1'b1;
      end
      OP_AND: begin
        w_acc_next = r_acc & mem_q;
        w_upd_zf   = 1'b1;
      end
      OP_OR: begin
        w_acc_next = r_acc | mem_q;
        w_upd_zf   = 1'b1;
      end
      OP_ADDI: begin
        w_sum9     = {1'b0, r_acc} + {1'b0, r_opa};
        w_acc_next = w_sum9[7:0];
        w_cf_next  = w_sum9[8];
        w_upd_zf   = 1'b1;
      end
      OP_HLT: begin
        w_halt_next = 1'b1;
      end
`ifdef ALU_SHIFT_EN
      OP_SHL: begin
        w_acc_next = {r_acc[6:0], 1'b0};
        w_cf_next  = r_acc[7];
        w_upd_zf   = 1'b1;
      end
      OP_SHR: begin
        w_acc_next = {1'b0, r_acc[7:1]};
        w_cf_next  = r_acc[0];
        w_upd_zf   = 1'b1;
      end
`else
      OP_SHL, OP_SHR: begin
        w_acc_next = r_acc;
      end
`endif
      default: begin
        w_acc_next = r_acc;
      end
    endcase
    if (w_upd_zf) begin
      w_zf_next = (w_acc_next == 8'h00);
    end
  end

  // Immediate operand latch, captured at the end of execa.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opa <= 8'h00;
    end else if (w_a_active && w_imm_op) begin
      r_opa <= irb;
    end
  end

  // Architectural state commit at the end of execb.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc  <= 8'h00;
      r_zf   <= 1'b0;
      r_cf   <= 1'b0;
      r_halt <= 1'b0;
    end else if (w_b_active) begin
      r_acc  <= w_acc_next;
      r_zf   <= w_zf_next;
      r_cf   <= w_cf_next;
      r_halt <= w_halt_next;
    end
  end

  assign acc  = r_acc;
  assign zf   = r_zf;
  assign cf   = r_cf;
  assign halt = r_halt;

endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: scoreboard bench for exec_unit. Expected post-instruction
// state is pushed when an instruction is driven and popped after execb.
module tb_exec_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       execa = 1'b0;
  logic       execb = 1'b0;
  logic [7:0] ira = 8'h00;
  logic [7:0] irb = 8'h00;
  logic [7:0] mem_q = 8'h00;
  logic [7:0] mem_addr, mem_data, pc_target, acc;
  logic       mem_rden, mem_wren, pc_load, halt, zf, cf;

  int n_total = 0;
  int n_pass  = 0;

  logic [10:0] sb_q[$];   // {halt, cf, zf, acc}

  // Reference model state
  logic [7:0] m_acc  = 8'h00;
  logic       m_zf   = 1'b0;
  logic       m_cf   = 1'b0;
  logic       m_halt = 1'b0;

  exec_unit dut (
    .clk(clk), .rst(rst), .execa(execa), .execb(execb),
    .ira(ira), .irb(irb), .mem_q(mem_q),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_rden(mem_rden), .mem_wren(mem_wren),
    .pc_load(pc_load), .pc_target(pc_target),
    .halt(halt), .acc(acc), .zf(zf), .cf(cf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Drive one instruction through execa/execb (or both-high when 'both').
  task automatic instr(input logic [3:0] op, input logic [7:0] operand,
                       input logic [7:0] mq, input bit both);
    logic [7:0] e_acc;
    logic       e_zf, e_cf, e_halt, e_jump, e_rd, e_wr;
    logic [8:0] s9;
    logic [10:0] got_state, exp_state;
    e_acc = m_acc; e_zf = m_zf; e_cf = m_cf; e_halt = m_halt; e_jump = 1'b0;
    if (!m_halt) begin
      case (op)
        4'h1: e_acc = operand;
        4'h2: e_acc = mq;
        4'h4: begin s9 = m_acc + mq; {e_cf, e_acc} = s9; end
        4'h5: begin s9 = {1'b0, m_acc} - {1'b0, mq}; {e_cf, e_acc} = s9; end
        4'h6: e_acc = m_acc & mq;
        4'h7: e_acc = m_acc | mq;
        4'h8: begin s9 = m_acc + operand; {e_cf, e_acc} = s9; end
        4'h9: e_jump = 1'b1;
        4'hA: e_jump = m_zf;
        4'hB: e_jump = m_cf;
        4'hC: e_halt = 1'b1;
`ifdef ALU_SHIFT_EN
        4'hD: begin e_cf = m_acc[7]; e_acc = m_acc << 1; end
        4'hE: begin e_cf = m_acc[0]; e_acc = m_acc >> 1; end
`endif
        default: ;
      endcase
      if (op inside {4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8}) e_zf = (e_acc == 8'h00);
`ifdef ALU_SHIFT_EN
      if (op inside {4'hD, 4'hE}) e_zf = (e_acc == 8'h00);
`endif
    end
    e_rd = !m_halt && !both && (op inside {4'h2, 4'h4, 4'h5, 4'h6, 4'h7});
    e_wr = !m_halt && !both && (op == 4'h3);
    sb_q.push_back({e_halt, e_cf, e_zf, e_acc});

    if (!both) begin
      @(posedge clk); #1;
      ira = {op, 4'h0}; irb = operand; execa = 1'b1; execb = 1'b0;
      #2;
      check("a_rden", mem_rden, e_rd);
      check("a_wren", mem_wren, e_wr);
      check("a_addr", mem_addr, m_halt ? 8'h00 : operand);
      check("a_data", mem_data, m_halt ? 8'h00 : m_acc);
      check("a_pcld", pc_load, 1'b0);
    end
    @(posedge clk); #1;
    ira = {op, 4'h0}; irb = operand; execa = both; execb = 1'b1; mem_q = mq;
    #2;
    check("b_pcld", pc_load, e_jump);
    check("b_pctg", pc_target, e_jump ? operand : 8'h00);
    check("b_rden", mem_rden, 1'b0);
    check("b_wren", mem_wren, 1'b0);
    @(posedge clk); #1;
    execa = 1'b0; execb = 1'b0;
    exp_state = sb_q.pop_front();
    got_state = {halt, cf, zf, acc};
    check($sformatf("st_op%0h", op), got_state, exp_state);
    m_acc = e_acc; m_zf = e_zf; m_cf = e_cf; m_halt = e_halt;
    $display("op=%0h irb=%02h mq=%02h -> acc=%02h zf=%0b cf=%0b halt=%0b",
             op, operand, mq, acc, zf, cf, halt);
  endtask

  initial begin
    // Reset with an ST pending: outputs must stay quiet.
    execa = 1'b1; ira = 8'h30; irb = 8'h55;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wren", mem_wren, 1'b0);
    check("rst_addr", mem_addr, 8'h00);
    check("rst_acc", acc, 8'h00);
    check("rst_flags", {halt, zf, cf}, 3'b000);
    execa = 1'b0; rst = 1'b0;

    instr(4'h1, 8'h5A, 8'h00, 0);   // LDI 5A
    instr(4'h3, 8'h20, 8'h00, 0);   // ST 20
    instr(4'h2, 8'h20, 8'h5A, 0);   // LD 20
    instr(4'h1, 8'hF0, 8'h00, 0);   // LDI F0
    instr(4'h4, 8'h30, 8'h20, 0);   // ADD -> 10, cf=1
    instr(4'hB, 8'h33, 8'h00, 0);   // JC taken
    instr(4'h5, 8'h31, 8'h10, 0);   // SUB -> 00, zf=1
    instr(4'hA, 8'h40, 8'h00, 0);   // JZ taken
    instr(4'hB, 8'h44, 8'h00, 0);   // JC not taken
    instr(4'h1, 8'h01, 8'h00, 0);   // LDI 01
    instr(4'hA, 8'h40, 8'h00, 0);   // JZ not taken
    instr(4'h6, 8'h32, 8'h0F, 0);   // AND
    instr(4'h7, 8'h33, 8'h80, 0);   // OR -> 81
    instr(4'h8, 8'hFF, 8'h00, 0);   // ADDI FF -> 80, cf=1
    instr(4'h5, 8'h34, 8'h81, 0);   // SUB borrow -> FF
    instr(4'h1, 8'h81, 8'h00, 0);   // LDI 81
    instr(4'hD, 8'h00, 8'h00, 0);   // SHL / NOP
    instr(4'hE, 8'h00, 8'h00, 0);   // SHR / NOP
    instr(4'h9, 8'h12, 8'h00, 0);   // JMP
    instr(4'h0, 8'h00, 8'h00, 0);   // NOP
    instr(4'hF, 8'h00, 8'h00, 0);   // NOP
    instr(4'h4, 8'h00, 8'h03, 1);   // ADD with both phases high
    for (int i = 0; i < 4; i++)     // random ALU ops
      instr(4'h4 + 4'(i), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0);

    // Reset in the middle of execb.
    instr(4'h1, 8'h77, 8'h00, 0);
    @(posedge clk); #1;
    ira = 8'h10; irb = 8'h42; execa = 1'b1;
    @(posedge clk); #1;
    execa = 1'b0; execb = 1'b1;
    #2; rst = 1'b1; #1;
    check("mid_rst_acc", acc, 8'h00);
    check("mid_rst_flags", {halt, zf, cf}, 3'b000);
    @(posedge clk); #1;
    execb = 1'b0; rst = 1'b0;
    check("post_rst_acc", acc, 8'h00);
    m_acc = 8'h00; m_zf = 1'b0; m_cf = 1'b0; m_halt = 1'b0;

    instr(4'h1, 8'h3C, 8'h00, 0);   // LDI 3C
    instr(4'hC, 8'h00, 8'h00, 0);   // HLT
    instr(4'h1, 8'hFF, 8'h00, 0);   // ignored
    instr(4'h3, 8'h22, 8'h00, 0);   // ignored, no strobe
    instr(4'h9, 8'h50, 8'h00, 0);   // ignored, no pc_load

    // Reset mid-execb clears halt at once.
    @(posedge clk); #1;
    ira = 8'h10; irb = 8'hFF; execb = 1'b1;
    #2; rst = 1'b1; #1;
    check("hlt_rst_halt", halt, 1'b0);
    check("hlt_rst_acc", acc, 8'h00);
    @(posedge clk); #1;
    execb = 1'b0; rst = 1'b0;
    m_acc = 8'h00; m_zf = 1'b0; m_cf = 1'b0; m_halt = 1'b0;
    instr(4'h1, 8'h00, 8'h00, 0);   // LDI 00 -> zf=1 after recovery

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
